// File: rtl/loop_sequencer.sv
// loop_sequencer: sequences the Q-regulation loop.
// It waits out a settling delay, then issues a one-cycle measurement start and waits
// for ready. It evaluates the result against q_desired and repeats while enable is
// high. Lock is declared after LOCK_COUNT consecutive in-tolerance evaluations. A
// measurement that never completes parks the sequencer in FAULT.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   enable       run request; low returns to IDLE at the next edge
//   q_desired    target Q, sampled in EVAL
//   ready        measurement-complete strobe, with q_measured valid alongside
//   q_measured   measurement result
//   start        one-cycle measurement trigger
//   loop_enable  enable to the bisection controller (high in SETTLE..EVAL)
//   locked       loop locked
//   timeout_err  measurement timeout fault
//   busy         sequencer not idle
//   iter_count   completed evaluations since enable, saturating
//   q_last       last captured q_measured
module loop_sequencer #(
  parameter int unsigned BUS_WIDTH      = 10,
  parameter int unsigned TOL            = 1,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned ITER_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [BUS_WIDTH-1:0]  q_desired,
  input  logic                  ready,
  input  logic [BUS_WIDTH-1:0]  q_measured,
  output logic                  start,
  output logic                  loop_enable,
  output logic                  locked,
  output logic                  timeout_err,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [BUS_WIDTH-1:0]  q_last
);

  localparam int unsigned SETTLE_W  = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RUN_W     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned DIFF_W    = BUS_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    START   = 3'd2,
    MEASURE = 3'd3,
    EVAL    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t                state;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [TIMEOUT_W-1:0]  timeout_cnt;
  logic [RUN_W-1:0]      lock_run;
  logic [BUS_WIDTH-1:0]  q_ref;

  logic signed [DIFF_W-1:0] diff_s;
  logic [DIFF_W-1:0]        diff_abs;
  logic                     in_tol;
  logic                     q_changed;
  logic [RUN_W-1:0]         run_base;
  logic [RUN_W-1:0]         run_next;

  // Evaluation datapath: extra sign bit so the difference never wraps.
  // A changed target discards the run before this evaluation is counted.
  always_comb begin
    diff_s    = $signed({1'b0, q_last}) - $signed({1'b0, q_desired});
    diff_abs  = diff_s[DIFF_W-1] ? DIFF_W'(-diff_s) : DIFF_W'(diff_s);
    in_tol    = (diff_abs <= DIFF_W'(TOL));
    q_changed = (q_desired != q_ref);
    run_base  = q_changed ? '0 : lock_run;
    run_next  = (run_base < RUN_W'(LOCK_COUNT)) ? run_base + RUN_W'(1) : run_base;
  end

  // Sequencer FSM with registered outputs.
  // enable=0 overrides every state, including FAULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start       <= 1'b0;
      loop_enable <= 1'b0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      iter_count  <= '0;
      q_last      <= '0;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      lock_run    <= '0;
      q_ref       <= '0;
    end else if (!enable) begin
      // IDLE entry / stay: clear run state, keep q_last for inspection.
      state       <= IDLE;
      start       <= 1'b0;
      loop_enable <= 1'b0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      iter_count  <= '0;
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      lock_run    <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          state       <= SETTLE;
          settle_cnt  <= SETTLE_W'(SETTLE_CYCLES);
          busy        <= 1'b1;
          loop_enable <= 1'b1;
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else begin
            state <= START;
            start <= 1'b1;
          end
        end
        START: begin
          timeout_cnt <= '0;
          state       <= MEASURE;
        end
        MEASURE: begin
          // ready on the last allowed cycle still completes the measurement.
          if (ready) begin
            q_last <= q_measured;
            state  <= EVAL;
          end else if (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= FAULT;
            timeout_err <= 1'b1;
            loop_enable <= 1'b0;
          end else begin
            timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
          end
        end
        EVAL: begin
          if (iter_count != {ITER_WIDTH{1'b1}}) begin
            iter_count <= iter_count + ITER_WIDTH'(1);
          end
          q_ref <= q_desired;
          if (in_tol) begin
            lock_run <= run_next;
            locked   <= (run_next == RUN_W'(LOCK_COUNT));
          end else begin
            lock_run <= '0;
            locked   <= 1'b0;
          end
          state      <= SETTLE;
          settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
        end
        FAULT: begin
          // Held until enable drops.
          loop_enable <= 1'b0;
          timeout_err <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          loop_enable <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed testbench for loop_sequencer with default parameters.
// Edge k is the k-th rising edge after enable is first driven high. Outputs are
// sampled 1 time unit after each rising edge.
module tb_loop_sequencer;

  localparam int unsigned T_OUT = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] q_desired;
  logic       ready;
  logic [9:0] q_measured;
  logic       start;
  logic       loop_enable;
  logic       locked;
  logic       timeout_err;
  logic       busy;
  logic [7:0] iter_count;
  logic [9:0] q_last;

  int n_cmp = 0;
  int n_err = 0;

  loop_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .q_desired   (q_desired),
    .ready       (ready),
    .q_measured  (q_measured),
    .start       (start),
    .loop_enable (loop_enable),
    .locked      (locked),
    .timeout_err (timeout_err),
    .busy        (busy),
    .iter_count  (iter_count),
    .q_last      (q_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a start pulse, then answer with q after lat MEASURE cycles.
  // Returns once the EVAL result is visible on the outputs.
  task automatic do_iter(input logic [9:0] q, input int lat, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (start) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (got) begin
      tick();
      repeat (lat) tick();
      ready      = 1'b1;
      q_measured = q;
      tick();
      ready      = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; ready = 1'b0; q_desired = 10'd500; q_measured = '0;
    tick(); tick();
    n_cmp++; if (start !== 1'b0)       begin n_err++; $display("FAIL reset_start: got %b exp 0", start); end
    n_cmp++; if (loop_enable !== 1'b0) begin n_err++; $display("FAIL reset_loop_enable: got %b exp 0", loop_enable); end
    n_cmp++; if (locked !== 1'b0)      begin n_err++; $display("FAIL reset_locked: got %b exp 0", locked); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b exp 0", timeout_err); end
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (iter_count !== 8'd0)  begin n_err++; $display("FAIL reset_iter: got %0d exp 0", iter_count); end
    n_cmp++; if (q_last !== 10'd0)     begin n_err++; $display("FAIL reset_q_last: got %0d exp 0", q_last); end
    rst = 1'b0;
    tick();
  endtask

  // Enable sampled at edge 0; start must be high only after edge 17.
  task automatic test_startup();
    enable = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b1)        begin n_err++; $display("FAIL startup_busy: got %b exp 1", busy); end
    n_cmp++; if (loop_enable !== 1'b1) begin n_err++; $display("FAIL startup_loop_enable: got %b exp 1", loop_enable); end
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (start !== (k == 17)) begin
        n_err++; $display("FAIL startup_start_edge%0d: got %b exp %b", k, start, (k == 17));
      end
    end
    // Now in MEASURE: first measurement far out of tolerance.
    ready = 1'b1; q_measured = 10'd480;
    tick();
    ready = 1'b0;
    n_cmp++; if (q_last !== 10'd480) begin n_err++; $display("FAIL startup_q_last: got %0d exp 480", q_last); end
    tick();
    n_cmp++; if (iter_count !== 8'd1) begin n_err++; $display("FAIL startup_iter: got %0d exp 1", iter_count); end
    n_cmp++; if (locked !== 1'b0)     begin n_err++; $display("FAIL startup_locked: got %b exp 0", locked); end
  endtask

  task automatic test_lock();
    logic [9:0] qs [4] = '{10'd499, 10'd501, 10'd500, 10'd500};
    bit got;
    for (int i = 0; i < 4; i++) begin
      do_iter(qs[i], 2, got);
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL lock_start%0d: got %b exp 1", i, got); end
      n_cmp++; if (iter_count !== 8'(i + 2)) begin n_err++; $display("FAIL lock_iter%0d: got %0d exp %0d", i, iter_count, i + 2); end
      n_cmp++; if (locked !== (i == 3)) begin n_err++; $display("FAIL lock_locked%0d: got %b exp %b", i, locked, (i == 3)); end
    end
  endtask

  task automatic test_unlock();
    bit got;
    do_iter(10'd510, 1, got);
    n_cmp++; if (got !== 1'b1)        begin n_err++; $display("FAIL unlock_start: got %b exp 1", got); end
    n_cmp++; if (locked !== 1'b0)     begin n_err++; $display("FAIL unlock_locked: got %b exp 0", locked); end
    n_cmp++; if (iter_count !== 8'd6) begin n_err++; $display("FAIL unlock_iter: got %0d exp 6", iter_count); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++;
      if (start !== (k == 17)) begin
        n_err++; $display("FAIL unlock_settle_edge%0d: got %b exp %b", k, start, (k == 17));
      end
    end
    // Run restarted: needs four fresh in-tolerance evaluations.
    for (int i = 0; i < 4; i++) begin
      do_iter(10'd500, 0, got);
      n_cmp++; if (locked !== (i == 3)) begin n_err++; $display("FAIL relock_locked%0d: got %b exp %b", i, locked, (i == 3)); end
    end
    n_cmp++; if (iter_count !== 8'd10) begin n_err++; $display("FAIL relock_iter: got %0d exp 10", iter_count); end
  endtask

  task automatic test_qdes_change();
    bit got;
    q_desired = 10'd300;
    for (int i = 0; i < 4; i++) begin
      do_iter(10'd300, 1, got);
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL qdes_start%0d: got %b exp 1", i, got); end
      n_cmp++; if (locked !== (i == 3)) begin n_err++; $display("FAIL qdes_locked%0d: got %b exp %b", i, locked, (i == 3)); end
    end
    n_cmp++; if (iter_count !== 8'd14) begin n_err++; $display("FAIL qdes_iter: got %0d exp 14", iter_count); end
    n_cmp++; if (q_last !== 10'd300)   begin n_err++; $display("FAIL qdes_q_last: got %0d exp 300", q_last); end
  endtask

  // Drop enable during MEASURE; late ready must not disturb anything.
  task automatic test_abort();
    bit seen = 1'b0;
    int stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (start) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_start_seen: got %b exp 1", seen); end
    tick();
    enable = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL abort_busy: got %b exp 0", busy); end
    n_cmp++; if (locked !== 1'b0)      begin n_err++; $display("FAIL abort_locked: got %b exp 0", locked); end
    n_cmp++; if (iter_count !== 8'd0)  begin n_err++; $display("FAIL abort_iter: got %0d exp 0", iter_count); end
    n_cmp++; if (loop_enable !== 1'b0) begin n_err++; $display("FAIL abort_loop_enable: got %b exp 0", loop_enable); end
    ready = 1'b1; q_measured = 10'd777;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (start !== 1'b0 || busy !== 1'b0) stray++;
    end
    ready = 1'b0;
    n_cmp++; if (stray !== 0)        begin n_err++; $display("FAIL abort_stray: got %0d exp 0", stray); end
    n_cmp++; if (q_last !== 10'd300) begin n_err++; $display("FAIL abort_q_last: got %0d exp 300", q_last); end
  endtask

  // Reset in SETTLE returns everything to reset values; ready afterwards ignored.
  task automatic test_rst_settle();
    int stray = 0;
    enable = 1'b1;
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b exp 1", busy); end
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (iter_count !== 8'd0) begin n_err++; $display("FAIL rst_iter: got %0d exp 0", iter_count); end
    n_cmp++; if (q_last !== 10'd0)    begin n_err++; $display("FAIL rst_q_last: got %0d exp 0", q_last); end
    ready = 1'b1; q_measured = 10'd55;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start !== 1'b0 || busy !== 1'b0 || q_last !== 10'd0) stray++;
    end
    ready = 1'b0;
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL rst_stray: got %0d exp 0", stray); end
  endtask

  // No ready: FAULT becomes visible 1025 edges after the start edge.
  task automatic test_timeout();
    bit seen = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (start) begin seen = 1'b1; break; end
      tick();
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL to_start_seen: got %b exp 1", seen); end
    repeat (T_OUT) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_early_err: got %b exp 0", timeout_err); end
    n_cmp++; if (loop_enable !== 1'b1) begin n_err++; $display("FAIL to_early_loop_enable: got %b exp 1", loop_enable); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b exp 1", timeout_err); end
    n_cmp++; if (loop_enable !== 1'b0) begin n_err++; $display("FAIL to_loop_enable: got %b exp 0", loop_enable); end
    repeat (30) tick();
    n_cmp++; if (timeout_err !== 1'b1 || start !== 1'b0) begin
      n_err++; $display("FAIL to_hold: got err=%b start=%b exp err=1 start=0", timeout_err, start);
    end
    enable = 1'b0;
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear_err: got %b exp 0", timeout_err); end
    n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL to_clear_busy: got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock();
    test_unlock();
    test_qdes_change();
    test_abort();
    test_rst_settle();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
